program_loader: RTL and testbench

- Serial program-load front end for the processor: receives a byte stream on a UART-style line (8N1).
- Assembles the bytes into 32-bit instruction words and writes them into instruction memory.
- Holds the control unit and datapath in reset until the load completes.
- Inbound counterpart of the register-display output path: external data into the core rather than core state out to GPIO.

---
 rtl/program_loader_pkg.sv | 21 ++
 rtl/program_loader_if.sv | 23 ++
 rtl/program_loader_uart_rx.sv | 79 +++++++
 rtl/program_loader.sv | 124 ++++++++++++
 tb/tb_program_loader.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// Shared encodings for the serial program loader: receiver and loader FSM states
// and the width of the word-count field carried at the head of the stream.
package program_loader_pkg;

  localparam int COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    CNT_LO,
    CNT_HI,
    WORD,
    DONE
  } load_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Bus between the program loader and its surroundings: serial input, instruction
// memory write port and the status/hold outputs.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  rx;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  frame_error;

  modport master (
    input  rx,
    output mem_we, mem_addr, mem_wdata, cpu_hold, load_done, frame_error
  );

  modport slave (
    output rx,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, load_done, frame_error
  );
endinterface

// File: rtl/program_loader_uart_rx.sv
// 8N1 byte receiver: rx synchronizer, bit timer and start/data/stop FSM.
// byte_valid and stop_error are single-cycle pulses in the stop-bit sample cycle.
module uart_rx_byte
  import program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       stop_error
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_s, half_hit, bit_hit;

  // Two-stage synchronizer; resets to the idle-high line level.
  assign sync_d   = {sync_q[0], rx};
  assign rx_s     = sync_q[1];
  assign half_hit = (cnt_q == CW'(HALF - 1));
  assign bit_hit  = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RX_IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      RX_IDLE:  if (!rx_s) state_d = RX_START;
      RX_START: if (half_hit) state_d = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_hit && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (bit_hit) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (state_q == RX_IDLE || state_d != state_q || bit_hit) cnt_d = '0;
    if (state_q == RX_IDLE) bit_d = '0;
    if (state_q == RX_DATA && bit_hit) begin
      shift_d = {rx_s, shift_q[7:1]};
      bit_d   = bit_q + 1'b1;
    end
  end

  always_comb begin
    byte_valid = (state_q == RX_STOP) && bit_hit && rx_s;
    stop_error = (state_q == RX_STOP) && bit_hit && !rx_s;
    rx_byte    = shift_q;
  end

endmodule

// File: rtl/program_loader.sv
// Serial program loader: parses a count-prefixed little-endian word stream into
// instruction-memory writes and holds the CPU until the whole program is in.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic              clock,
  input  logic              reset,
  program_loader_if.master  bus
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

  logic       byte_valid, stop_error;
  logic [7:0] rx_byte;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (bus.rx),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .stop_error (stop_error)
  );

  load_state_e            state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] word_idx_q, word_idx_d, next_idx;
  logic [1:0]             byte_idx_q, byte_idx_d;
  logic [31:0]            asm_q, asm_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]            mem_wdata_q, mem_wdata_d;
  logic                   load_done_q, cpu_hold_q, frame_error_q;
  logic                   load_done_d, cpu_hold_d, frame_error_d;
  logic                   last_byte, in_range;

  assign next_idx  = word_idx_q + 1'b1;
  assign last_byte = byte_valid && (byte_idx_q == 2'd3);
  // Words past the end of memory are still consumed so the count stays honoured.
  assign in_range  = 32'(word_idx_q) < DEPTH;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= CNT_LO;
      count_q       <= '0;
      word_idx_q    <= '0;
      byte_idx_q    <= '0;
      asm_q         <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      load_done_q   <= 1'b0;
      cpu_hold_q    <= 1'b1;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      word_idx_q    <= word_idx_d;
      byte_idx_q    <= byte_idx_d;
      asm_q         <= asm_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      load_done_q   <= load_done_d;
      cpu_hold_q    <= cpu_hold_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CNT_LO: if (byte_valid) state_d = CNT_HI;
      CNT_HI: if (byte_valid) state_d = ({rx_byte, count_q[7:0]} == '0) ? DONE : WORD;
      WORD:   if (last_byte && next_idx == count_q) state_d = DONE;
      DONE:   state_d = DONE;
      default: state_d = CNT_LO;
    endcase
  end

  always_comb begin
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      CNT_LO: if (byte_valid) count_d[7:0] = rx_byte;
      CNT_HI: if (byte_valid) begin
        count_d[15:8] = rx_byte;
        word_idx_d    = '0;
        byte_idx_d    = '0;
      end
      WORD: if (byte_valid) begin
        asm_d      = {rx_byte, asm_q[31:8]};
        byte_idx_d = byte_idx_q + 1'b1;
        if (last_byte) begin
          mem_we_d    = in_range;
          mem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
          mem_wdata_d = {rx_byte, asm_q[31:8]};
          word_idx_d  = next_idx;
        end
      end
      default: ;
    endcase
    // Status lags the state by one cycle so it follows the final write strobe.
    load_done_d   = (state_q == DONE);
    cpu_hold_d    = (state_q != DONE);
    frame_error_d = frame_error_q | stop_error;
  end

  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.load_done   = load_done_q;
  assign bus.cpu_hold    = cpu_hold_q;
  assign bus.frame_error = frame_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with CLKS_PER_BIT=4 and ADDR_WIDTH=4.
// A negedge monitor logs every write strobe and the first load_done cycle.
module tb_program_loader;

  localparam int CPB = 4;
  localparam int AW  = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  program_loader_if #(.ADDR_WIDTH(AW)) bus ();

  program_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          we_count = 0;
  int          last_we_cyc = -1;
  int          done_cyc = -1;
  bit          done_seen = 1'b0;
  logic        hold_at_last_we = 1'b0;
  logic [AW-1:0] we_addr [64];
  logic [31:0]   we_data [64];
  logic [7:0]    stream [$];

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (bus.mem_we === 1'b1) begin
      if (we_count < 64) begin
        we_addr[we_count] = bus.mem_addr;
        we_data[we_count] = bus.mem_wdata;
      end
      we_count        = we_count + 1;
      last_we_cyc     = cyc;
      hold_at_last_we = bus.cpu_hold;
    end
    if (bus.load_done === 1'b1 && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    we_count    = 0;
    last_we_cyc = -1;
    done_cyc    = -1;
    done_seen   = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset  = 1'b0;
    bus.rx = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    @(negedge clock);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    bus.rx = stop_bit;
    repeat (CPB) @(negedge clock);
    bus.rx = 1'b1;
  endtask

  task automatic send_stream();
    foreach (stream[i]) send_byte(stream[i]);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (bus.load_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    idle(4);
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    bus.rx = 1'b1;
    #2;
    n_vec++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", bus.mem_we); end
    n_vec++; if (bus.mem_addr !== 4'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr); end
    n_vec++; if (bus.mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", bus.mem_wdata); end
    n_vec++; if (bus.frame_error !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", bus.frame_error); end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    clear_log();
    repeat (1000) @(negedge clock);
    n_vec++; if (bus.cpu_hold !== 1'b1) begin n_err++; $display("FAIL idle_hold: got %b want 1", bus.cpu_hold); end
    n_vec++; if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL idle_done: got %b want 0", bus.load_done); end
    n_vec++; if (we_count !== 0) begin n_err++; $display("FAIL idle_we_count: got %0d want 0", we_count); end
  endtask

  task automatic test_two_words();
    bit ok;
    apply_reset();
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stream();
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL two_done_timeout: got load_done=%b want 1", bus.load_done); end
    n_vec++; if (we_count !== 2) begin n_err++; $display("FAIL two_we_count: got %0d want 2", we_count); end
    n_vec++; if ({we_addr[0], we_data[0]} !== {4'h0, 32'h12345678}) begin n_err++; $display("FAIL two_word0: got %h/%h want 0/12345678", we_addr[0], we_data[0]); end
    n_vec++; if ({we_addr[1], we_data[1]} !== {4'h1, 32'hDEADBEEF}) begin n_err++; $display("FAIL two_word1: got %h/%h want 1/deadbeef", we_addr[1], we_data[1]); end
    n_vec++; if (hold_at_last_we !== 1'b1) begin n_err++; $display("FAIL two_hold_at_we: got %b want 1", hold_at_last_we); end
    n_vec++; if (done_cyc !== last_we_cyc + 1) begin n_err++; $display("FAIL two_done_timing: got cycle %0d want %0d", done_cyc, last_we_cyc + 1); end
    n_vec++; if (bus.cpu_hold !== 1'b0) begin n_err++; $display("FAIL two_hold: got %b want 0", bus.cpu_hold); end
  endtask

  task automatic test_zero_count();
    bit ok;
    apply_reset();
    stream = '{8'h00, 8'h00};
    send_stream();
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL zero_done_timeout: got load_done=%b want 1", bus.load_done); end
    n_vec++; if (bus.cpu_hold !== 1'b0) begin n_err++; $display("FAIL zero_hold: got %b want 0", bus.cpu_hold); end
    send_byte(8'h55);
    idle(20);
    n_vec++; if ({bus.load_done, bus.cpu_hold} !== 2'b10) begin n_err++; $display("FAIL zero_after_extra: got done/hold %b%b want 10", bus.load_done, bus.cpu_hold); end
    n_vec++; if (we_count !== 0) begin n_err++; $display("FAIL zero_we_count: got %0d want 0", we_count); end
  endtask

  task automatic test_glitch();
    bit ok;
    apply_reset();
    // Low for one clock: shorter than half a bit, so the start check sees high again.
    bus.rx = 1'b0;
    @(negedge clock);
    idle(12);
    stream = '{8'h01, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    send_stream();
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL glitch_done_timeout: got load_done=%b want 1", bus.load_done); end
    n_vec++; if (we_count !== 1) begin n_err++; $display("FAIL glitch_we_count: got %0d want 1", we_count); end
    n_vec++; if ({we_addr[0], we_data[0]} !== {4'h0, 32'hAABBCCDD}) begin n_err++; $display("FAIL glitch_word: got %h/%h want 0/aabbccdd", we_addr[0], we_data[0]); end
    n_vec++; if (bus.frame_error !== 1'b0) begin n_err++; $display("FAIL glitch_ferr: got %b want 0", bus.frame_error); end
  endtask

  task automatic test_frame_error();
    bit ok;
    apply_reset();
    stream = '{8'h01, 8'h00, 8'h44, 8'h33};
    send_stream();
    send_byte(8'h99, 1'b0);
    idle(8);
    n_vec++; if (bus.frame_error !== 1'b1) begin n_err++; $display("FAIL ferr_set: got %b want 1", bus.frame_error); end
    n_vec++; if (we_count !== 0) begin n_err++; $display("FAIL ferr_early_we: got %0d want 0", we_count); end
    stream = '{8'h22, 8'h11};
    send_stream();
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL ferr_done_timeout: got load_done=%b want 1", bus.load_done); end
    n_vec++; if (we_count !== 1) begin n_err++; $display("FAIL ferr_we_count: got %0d want 1", we_count); end
    n_vec++; if ({we_addr[0], we_data[0]} !== {4'h0, 32'h11223344}) begin n_err++; $display("FAIL ferr_word: got %h/%h want 0/11223344", we_addr[0], we_data[0]); end
    n_vec++; if (bus.frame_error !== 1'b1) begin n_err++; $display("FAIL ferr_sticky: got %b want 1", bus.frame_error); end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] lo, hi;
    apply_reset();
    stream = '{8'h11, 8'h00};
    for (int w = 0; w < 17; w++) begin
      lo = 8'(w);
      hi = 8'(w + 1);
      stream.push_back(lo);
      stream.push_back(hi);
      stream.push_back(8'h5A);
      stream.push_back(8'hC3);
    end
    send_stream();
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL ovf_done_timeout: got load_done=%b want 1", bus.load_done); end
    n_vec++; if (we_count !== 16) begin n_err++; $display("FAIL ovf_we_count: got %0d want 16", we_count); end
    for (int w = 0; w < 16; w++) begin
      lo = 8'(w);
      hi = 8'(w + 1);
      n_vec++;
      if ({we_addr[w], we_data[w]} !== {4'(w), 8'hC3, 8'h5A, hi, lo}) begin
        n_err++;
        $display("FAIL ovf_word%0d: got %h/%h want %h/%h", w, we_addr[w], we_data[w], 4'(w), {8'hC3, 8'h5A, hi, lo});
      end
    end
    // The unwritten 17th word spans four more byte times before DONE.
    n_vec++; if (done_cyc - last_we_cyc <= 100) begin n_err++; $display("FAIL ovf_done_gap: got %0d cycles want >100", done_cyc - last_we_cyc); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    n_vec++; if ({bus.mem_addr, bus.mem_wdata} !== {4'h0, 32'h0}) begin n_err++; $display("FAIL rst_async_bus: got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata); end
    n_vec++; if ({bus.load_done, bus.cpu_hold, bus.mem_we} !== 3'b010) begin n_err++; $display("FAIL rst_async_status: got done/hold/we %b%b%b want 010", bus.load_done, bus.cpu_hold, bus.mem_we); end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    clear_log();
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34};
    send_stream();
    idle(10);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    n_vec++; if ({bus.load_done, bus.cpu_hold, bus.frame_error} !== 3'b010) begin n_err++; $display("FAIL rst_mid_status: got done/hold/ferr %b%b%b want 010", bus.load_done, bus.cpu_hold, bus.frame_error); end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    clear_log();
    stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stream();
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rst_done_timeout: got load_done=%b want 1", bus.load_done); end
    n_vec++; if (we_count !== 1) begin n_err++; $display("FAIL rst_we_count: got %0d want 1", we_count); end
    n_vec++; if ({we_addr[0], we_data[0]} !== {4'h0, 32'hDEADBEEF}) begin n_err++; $display("FAIL rst_word: got %h/%h want 0/deadbeef", we_addr[0], we_data[0]); end
  endtask

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_two_words();
    test_zero_count();
    test_glitch();
    test_frame_error();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
